// File: rtl/sram_pkg.sv
// Shared SRAM definitions: read-during-write policy, read-latency limits
// and small helpers used by the multi-port synchronous-read memory.
package sram_pkg;

  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } wr_mode_e;

  localparam int RD_LAT_MAX = 2;
  localparam int NRD_MAX    = 4;

  // Address width for a given depth; a single-word memory still needs one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Only one- and two-stage read pipelines are implemented.
  function automatic bit rd_lat_ok(input int lat);
    return (lat >= 1) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/sync_read_mem_mp_if.sv
// Bus bundle for the multi-port memory: one lane-masked write port plus
// NRD independent read ports with per-port valid flags.
interface sync_read_mem_mp_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 2,
  parameter int LANES  = 4,
  parameter int NRD    = 2
);

  logic                                     wen;
  logic [ADDR_W-1:0]                        waddr;
  logic [LANES-1:0]                         cs;
  logic [LANES-1:0][DATA_W-1:0]             wdata;
  logic [NRD-1:0]                           ren;
  logic [NRD-1:0][ADDR_W-1:0]               raddr;
  logic [NRD-1:0][LANES-1:0][DATA_W-1:0]    rdata;
  logic [NRD-1:0]                           rvalid;

  // Requester side: drives writes and read requests, receives read data.
  modport master (
    output wen, waddr, cs, wdata, ren, raddr,
    input  rdata, rvalid
  );

  // Memory side.
  modport slave (
    input  wen, waddr, cs, wdata, ren, raddr,
    output rdata, rvalid
  );

endinterface

// File: rtl/sync_read_port.sv
// One read port of the multi-port memory: the stage-0 forwarding/range mux,
// the stage-1 capture register and an optional second pipeline stage.
module sync_read_port
  import sram_pkg::*;
#(
  parameter int       DEPTH   = 2048,
  parameter int       DATA_W  = 2,
  parameter int       LANES   = 4,
  parameter int       RD_LAT  = 1,
  parameter wr_mode_e WR_MODE = WRITE_FIRST,
  parameter int       ADDR_W  = addr_width(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           i_ren,
  input  logic [ADDR_W-1:0]              i_raddr,
  input  logic [LANES-1:0][DATA_W-1:0]   i_memWord,
  input  logic                           i_wen,
  input  logic [ADDR_W-1:0]              i_waddr,
  input  logic [LANES-1:0]               i_cs,
  input  logic [LANES-1:0][DATA_W-1:0]   i_wdata,
  output logic [LANES-1:0][DATA_W-1:0]   o_rdata,
  output logic                           o_rvalid
);

  logic                           w_inRange;
  logic                           w_sameAddr;
  logic [LANES-1:0][DATA_W-1:0]   w_stage0;
  logic [LANES-1:0][DATA_W-1:0]   r_s1Data;
  logic                           r_s1Valid;

  assign w_inRange  = int'(i_raddr) < DEPTH;
  assign w_sameAddr = i_wen && (i_raddr == i_waddr);

  // Stage 0: pick stored or in-flight write data per lane; out-of-range reads return zero.
  always_comb begin
    w_stage0 = '0;
    if (w_inRange) begin
      for (int i = 0; i < LANES; i++) begin
        if ((WR_MODE == WRITE_FIRST) && w_sameAddr && i_cs[i]) begin
          w_stage0[i] = i_wdata[i];
        end else begin
          w_stage0[i] = i_memWord[i];
        end
      end
    end
  end

  // Stage 1: snapshot the word on a read request; data holds when idle so consumers see the last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1Data  <= '0;
      r_s1Valid <= 1'b0;
    end else begin
      r_s1Valid <= i_ren;
      if (i_ren) begin
        r_s1Data <= w_stage0;
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [LANES-1:0][DATA_W-1:0] r_s2Data;
    logic                         r_s2Valid;

    // Stage 2: valid always advances, data only moves forward behind a valid so the hold rule carries over.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s2Data  <= '0;
        r_s2Valid <= 1'b0;
      end else begin
        r_s2Valid <= r_s1Valid;
        if (r_s1Valid) begin
          r_s2Data <= r_s1Data;
        end
      end
    end

    assign o_rdata  = r_s2Data;
    assign o_rvalid = r_s2Valid;
  end else begin : g_lat1
    assign o_rdata  = r_s1Data;
    assign o_rvalid = r_s1Valid;
  end

endmodule

// File: rtl/sync_read_mem_mp.sv
// Multi-port synchronous-read, lane-masked memory used for cache tag/data
// arrays. One shared write port, NRD independent read ports, each with its
// own read pipeline; the storage array itself is never reset.
module sync_read_mem_mp
  import sram_pkg::*;
#(
  parameter int       DEPTH   = 2048,
  parameter int       DATA_W  = 2,
  parameter int       LANES   = 4,
  parameter int       NRD     = 2,
  parameter int       RD_LAT  = 1,
  parameter wr_mode_e WR_MODE = WRITE_FIRST,
  parameter int       ADDR_W  = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_read_mem_mp_if.slave bus
);

  if (!rd_lat_ok(RD_LAT)) begin : g_badRdLat
    $error("sync_read_mem_mp: RD_LAT must be 1 or 2");
  end
  if ((NRD < 1) || (NRD > NRD_MAX)) begin : g_badNrd
    $error("sync_read_mem_mp: NRD must be in 1..4");
  end
  if (LANES < 1) begin : g_badLanes
    $error("sync_read_mem_mp: LANES must be at least 1");
  end
  if (DEPTH < 1) begin : g_badDepth
    $error("sync_read_mem_mp: DEPTH must be at least 1");
  end

  logic [LANES-1:0][DATA_W-1:0]            r_mem [DEPTH];
  logic                                    w_waddrOk;
  logic [LANES-1:0][DATA_W-1:0]            w_memWord [NRD];
  logic [NRD-1:0][LANES-1:0][DATA_W-1:0]   w_rdata;
  logic [NRD-1:0]                          w_rvalid;

  assign w_waddrOk = int'(bus.waddr) < DEPTH;

  // Lane-masked write; addresses past the last word are silently dropped.
  always_ff @(posedge clk) begin
    if (bus.wen && w_waddrOk) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.cs[i]) begin
          r_mem[bus.waddr][i] <= bus.wdata[i];
        end
      end
    end
  end

  // Raw array lookup per port, guarded so an out-of-range address never indexes past the array.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      w_memWord[p] = '0;
      if (int'(bus.raddr[p]) < DEPTH) begin
        w_memWord[p] = r_mem[bus.raddr[p]];
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    sync_read_port #(
      .DEPTH   (DEPTH),
      .DATA_W  (DATA_W),
      .LANES   (LANES),
      .RD_LAT  (RD_LAT),
      .WR_MODE (WR_MODE),
      .ADDR_W  (ADDR_W)
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_ren     (bus.ren[p]),
      .i_raddr   (bus.raddr[p]),
      .i_memWord (w_memWord[p]),
      .i_wen     (bus.wen),
      .i_waddr   (bus.waddr),
      .i_cs      (bus.cs),
      .i_wdata   (bus.wdata),
      .o_rdata   (w_rdata[p]),
      .o_rvalid  (w_rvalid[p])
    );
  end

  assign bus.rdata  = w_rdata;
  assign bus.rvalid = w_rvalid;

endmodule
